// File: rtl/ex_mul_unit.sv
// EX-stage iterative shift-add multiplier: one partial product per cycle, low WIDTH bits kept.
// Optional macro MUL_EARLY_TERM_EN stops iterating once the remaining multiplier bits are all zero.
module ex_mul_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             stall
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    count_q, count_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] acc_step;
    logic             last_iter;

    always_comb begin
        acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
`ifdef MUL_EARLY_TERM_EN
        // Finish on the iteration that consumes the highest remaining set bit.
        last_iter = (count_q == CW'(WIDTH - 1)) || (mplier_q[WIDTH-1:1] == '0);
`else
        last_iter = (count_q == CW'(WIDTH - 1));
`endif
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    mcand_d  = A;
                    mplier_d = B;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
`ifdef MUL_EARLY_TERM_EN
                end else if (mplier_q == '0) begin
                    result_d = acc_q;
                    state_d  = S_DONE;
`endif
                end else begin
                    acc_d    = acc_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + CW'(1);
                    if (last_iter) begin
                        result_d = acc_step;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_d = (state_d != S_IDLE);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            result_q <= result_d;
            busy_q   <= busy_d;
        end
    end

    // A squash arriving in DONE suppresses the pulse so EX does not retire the result.
    assign done   = (state_q == S_DONE) && !flush;
    assign busy   = busy_q;
    assign stall  = ((state_q == S_IDLE) && start && !flush) || (state_q == S_RUN);
    assign result = result_q;

endmodule

// File: tb/tb_ex_mul_unit.sv
// Self-checking bench for ex_mul_unit: vector table, random products, and corner sequences.
module tb_ex_mul_unit;
    logic        Clk = 1'b0;
    logic        Rst, start, flush;
    logic [31:0] A, B, result;
    logic        done, busy, stall;

    int n_checks = 0;
    int n_fail   = 0;

    ex_mul_unit #(.WIDTH(32)) dut (
        .Clk(Clk), .Rst(Rst), .start(start), .flush(flush), .A(A), .B(B),
        .result(result), .done(done), .busy(busy), .stall(stall)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cycle of the done pulse counted from the accept cycle (0).
    function automatic int exp_lat(input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
        if (b == 0) return 2;
        for (int i = 31; i >= 0; i--)
            if (b[i]) return i + 2;
        return 2;
`else
        return 33;
`endif
    endfunction

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        return p[31:0];
    endfunction

    // Entered and left at a negedge. Start is presented in cycle 0 only.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic [31:0] res,
                           output int ndone, output int nstall);
        A = a; B = b; start = 1'b1; flush = 1'b0;
        #1;
        nstall = stall ? 1 : 0;
        lat = -1; ndone = 0; res = 'x;
        for (int cyc = 1; cyc < 100; cyc++) begin
            @(posedge Clk); #1;
            if (cyc == 1) start = 1'b0;
            @(negedge Clk);
            if (done) begin
                ndone++;
                if (lat < 0) begin lat = cyc; res = result; end
            end
            if (stall) nstall++;
            if (lat >= 0 && cyc >= lat + 3) break;
        end
    endtask

    task automatic do_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res);
        int lat, nd, ns;
        logic [31:0] r;
        run_mul(a, b, lat, r, nd, ns);
        check({name, " result"}, r, exp_res);
        check({name, " latency"}, lat, exp_lat(b));
        check({name, " done pulses"}, nd, 1);
        check({name, " stall cycles"}, ns, exp_lat(b));
    endtask

    initial begin
        vec_t vt[7];
        int   lat, nd, ns, seen;
        logic [31:0] r, ra, rb;

        vt[0] = '{32'd7, 32'd6, 32'd42};
        vt[1] = '{32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFB};
        vt[2] = '{32'h8000_0000, 32'd2, 32'd0};
        vt[3] = '{32'h1234_5678, 32'd0, 32'd0};
        vt[4] = '{32'd5, 32'd3, 32'd15};
        vt[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
        vt[6] = '{32'h1234_5679, 32'h8000_0000, 32'h8000_0000};

        Rst = 1'b1; start = 1'b0; flush = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk);
        check("reset result", result, 0);
        check("reset done", done, 0);
        check("reset busy", busy, 0);
        check("reset stall", stall, 0);

        foreach (vt[i]) do_vec($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].exp_res);

        repeat (10) @(negedge Clk);
        check("result held", result, vt[6].exp_res);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = (i % 4 == 0) ? ($urandom & 32'h0000_00FF) : $urandom;
            do_vec($sformatf("rand%0d", i), ra, rb, model(ra, rb));
        end

        // Flush at cycle 5: nothing completes, then a fresh start is accepted.
        do_vec("pre-flush", 32'd7, 32'd6, 32'd42);
        A = 32'd3; B = 32'd4; start = 1'b1;
        seen = 0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(posedge Clk); #1;
            start = 1'b0;
            @(negedge Clk);
            if (done) seen++;
            if (cyc == 5) flush = 1'b1;
        end
        @(posedge Clk); #1 flush = 1'b0;
        @(negedge Clk);
        check("flush busy", busy, 0);
        check("flush done", seen + int'(done), 0);
        check("flush result kept", result, 42);
        do_vec("after flush", 32'd2, 32'd9, 32'd18);

        // Reset at cycle 10 of a multiply.
        A = 32'd7; B = 32'hF000_0006; start = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge Clk); #1 start = 1'b0;
        end
        check("busy before reset", busy, 1);
        Rst = 1'b1;
        @(posedge Clk); #1 Rst = 1'b0;
        @(negedge Clk);
        check("mid-run reset busy", busy, 0);
        check("mid-run reset done", done, 0);
        check("mid-run reset result", result, 0);
        check("mid-run reset stall", stall, 0);
        seen = 0;
        repeat (40) begin @(negedge Clk); if (done) seen++; end
        check("no done after reset", seen, 0);

        // Start held high through two back-to-back multiplies.
        A = 32'd3; B = 32'd5; start = 1'b1;
        @(posedge Clk); #1 A = 32'd4; B = 32'd6;
        seen = 0; lat = -1;
        for (int cyc = 1; cyc < 100 && lat < 0; cyc++) begin
            @(negedge Clk);
            if (done) begin seen++; lat = cyc; r = result; end
            else begin @(posedge Clk); #1; end
        end
        check("held first result", r, 15);
        check("held first latency", lat, exp_lat(32'd5));
        @(posedge Clk); @(negedge Clk);
        check("held re-accept stall", stall, 1);
        check("held no double done", done, 0);
        nd = 0; lat = -1;
        for (int cyc = 1; cyc < 100 && lat < 0; cyc++) begin
            @(posedge Clk); #1;
            if (cyc == 1) start = 1'b0;
            @(negedge Clk);
            if (done) begin nd++; lat = cyc; r = result; end
        end
        check("held second result", r, 24);
        check("held second latency", lat, exp_lat(32'd6));
        check("held second done count", nd, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ex_mul_unit.md
# ex_mul_unit

Iterative shift-add multiplier in the EX stage, the execute-side consumer of the decoder's MUL ALU operation (ALU control code 8, SPECIAL2 `mul`). The EX stage starts it when a MUL instruction enters EX. It holds the pipeline with `stall` while it iterates, then returns the low `WIDTH` bits of the product with a one-cycle `done` pulse, so the instruction leaves EX with its result. All other ALU operations bypass this block.

## Interface
- `WIDTH`, default 32: operand and result width.
- `Clk` input 1: clock, rising edge.
- `Rst` input 1: synchronous, active-high reset.
- `start` input 1: EX holds a valid MUL instruction; sampled only in IDLE.
- `flush` input 1: squash the in-flight multiply (branch/jump redirect).
- `A` input `WIDTH`: multiplicand (rs), sampled with `start`.
- `B` input `WIDTH`: multiplier (rt), sampled with `start`.
- `result` output `WIDTH`: low `WIDTH` bits of A*B; held until the next accepted start.
- `done` output 1: one-cycle pulse; `result` is valid in this cycle.
- `busy` output 1: registered; high in RUN and DONE.
- `stall` output 1: combinational; freezes IF/ID/EX for the multiply.

## Operation
- State machine has three states: IDLE, RUN, DONE.
- **IDLE**
  - `start`=1 and `flush`=0: load `mcand`←A, `mplier`←B, `acc`←0, `count`←0, then go to RUN.
  - Otherwise stay in IDLE.
- **RUN**, one iteration per cycle:
  - If `mplier[0]`, then `acc`←`acc`+`mcand` (mod 2^WIDTH).
  - `mcand`←`mcand`<<1; `mplier`←`mplier`>>1; `count`←`count`+1.
  - When `count`=WIDTH-1 (last iteration), load `result` with the final acc and go to DONE.
- **DONE**: `done`=1 for exactly one cycle, then return to IDLE.
- Signedness: low WIDTH bits are identical for signed and unsigned operands. No sign handling is needed, and high bits are discarded.
- `stall` = (IDLE & `start` & !`flush`) | RUN. It is low in DONE, so the instruction advances at the DONE edge carrying `result`.
- `start` in RUN or DONE is ignored. The same instruction is still held in EX, so this is not a new request.
- `flush` in RUN or DONE: go to IDLE at the next edge. No `done` pulse, and `result` keeps its old value.
- `flush` together with `start` in IDLE: no start.
- `Rst` overrides everything, including mid-multiply.
- `count` width is clog2(WIDTH)+1 bits.

## Timing
- Reset values:
  - State IDLE.
  - `result`=0, `done`=0, `busy`=0, `stall`=0 (with `start`=0).
  - Internal `acc`, `mcand`, `mplier` and `count` are all 0.
- Full-length latency, with `start` accepted in cycle 0:
  - RUN occupies cycles 1..WIDTH.
  - `done`=1 in cycle WIDTH+1 (cycle 33 for WIDTH=32).
- `stall` is high in cycles 0..WIDTH, i.e. WIDTH+1 stall cycles.
- Back-to-back MULs: the earliest next accept is the cycle after DONE. `start` is ignored in DONE itself because that instruction is leaving.
- The reset edge returns the block to IDLE regardless of state. Any in-flight product is lost.

## Configuration
- Macro `MUL_EARLY_TERM_EN`.
- **Defined:** in RUN, if `mplier`=0 before an iteration, skip the iteration and go straight to DONE.
  - Latency becomes (index of highest set bit of B)+2 cycles to `done`.
  - B=0 gives `done` in cycle 2.
  - Worst case, B[WIDTH-1]=1, gives the full-length latency.
- **Undefined:** always WIDTH iterations; fixed latency of WIDTH+1.
- `result` values are identical in both builds.

## Test plan
- Reset mid-RUN (`Rst` at cycle 10 of a multiply) -> next cycle: state IDLE, `busy`=0, `done`=0, `result`=0; no `done` pulse follows.
- A=7, B=6, `start` at cycle 0 -> `stall` high in cycles 0..32, `done`=1 in cycle 33 only, `result`=42. `result` is still 42 ten cycles later.
- A=0xFFFFFFFF (-1), B=0x00000005 -> `result`=0xFFFFFFFB (-5), wrap-around checked. A=0x80000000, B=2 -> `result`=0.
- `flush` at cycle 5 of A=3, B=4 -> IDLE at cycle 6, no `done`, `result` unchanged. A new `start` at cycle 6 with A=2, B=9 is accepted -> `result`=18.
- `start` held high through RUN and DONE -> exactly one `done`. `start` still high in the cycle after DONE -> a second multiply begins with the newly sampled A and B.
- With `MUL_EARLY_TERM_EN`: B=0 gives `done` in cycle 2, `result`=0. A=5, B=3 gives `done` in cycle 3, `result`=15. Without the macro, both give `done` in cycle 33 with the same results.
